// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared state encoding and constants for the round-robin arbiter
//
// Purpose: state type, requester count, index width and default watchdog limit
//          used by rr_arbiter and rr_pick.
// Ports:   none (package).
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int ARB_N       = 8;
  localparam int ARB_IDW     = 3;
  localparam int ARB_TIMEOUT = 16;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: rotate then lowest-set-bit encode
//
// Purpose: find the first asserted request at ptr, ptr+1, ... wrapping at ARB_N.
// Ports:
//   req   - request vector
//   ptr   - index that has highest priority this round
//   found - some request is asserted
//   idx   - absolute index of the selected requester (valid when found)
module rr_pick
  import arb_pkg::*;
(
  input  logic [ARB_N-1:0]   req,
  input  logic [ARB_IDW-1:0] ptr,
  output logic               found,
  output logic [ARB_IDW-1:0] idx
);

  logic [ARB_N-1:0]   rot;
  logic [ARB_IDW-1:0] ofs;

  always_comb begin
    // Rotating the doubled vector puts requester ptr at bit 0.
    rot   = ARB_N'({req, req} >> ptr);
    found = |rot;
    ofs   = '0;
    // Scan from the top so the lowest set bit wins.
    for (int i = ARB_N - 1; i >= 0; i--) begin
      if (rot[i]) ofs = i[ARB_IDW-1:0];
    end
    // Index width equals log2(ARB_N), so this add wraps naturally.
    idx = ptr + ofs;
  end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with one-hot registered grant and optional watchdog
//
// Purpose: grants one requester at a time, holds the grant until done, a request
//          drop, or watchdog expiry, then inserts one idle cycle and rotates priority.
// Optional feature: define RR_ARBITER_TIMEOUT_EN to enable the grant watchdog.
// Ports:
//   clk         - clock, rising edge
//   reset       - asynchronous active-high reset
//   req         - request lines, bit i from requester i
//   done        - one-cycle release pulse from the current owner
//   grant       - one-hot registered grant, zero when no owner
//   grant_id    - binary index of the current (or last) owner
//   grant_valid - grant is non-zero
//   timeout     - one-cycle pulse when the watchdog revokes a grant
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N       = ARB_N,
  parameter int TIMEOUT = ARB_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       req,
  input  logic               done,
  output logic [N-1:0]       grant,
  output logic [ARB_IDW-1:0] grant_id,
  output logic               grant_valid,
  output logic               timeout
);

  arb_state_e         state, state_nxt;
  logic [ARB_IDW-1:0] ptr, ptr_nxt;
  logic [N-1:0]       grant_nxt;
  logic [ARB_IDW-1:0] grant_id_nxt;
  logic               found;
  logic [ARB_IDW-1:0] pick_idx;
  logic               expire;

  rr_pick u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      grant    <= '0;
      grant_id <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      grant    <= grant_nxt;
      grant_id <= grant_id_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    grant_nxt    = grant;
    grant_id_nxt = grant_id;
    case (state)
      IDLE: begin
        grant_nxt = '0;
        if (found) begin
          grant_nxt    = N'(1) << pick_idx;
          grant_id_nxt = pick_idx;
          state_nxt    = BUSY;
        end
      end
      BUSY: begin
        // Any release cause leads to the same single release; the next grant
        // is decided from IDLE, which yields the mandatory idle cycle.
        if (done || !req[grant_id] || expire) begin
          grant_nxt = '0;
          ptr_nxt   = grant_id + ARB_IDW'(1);
          state_nxt = IDLE;
        end
      end
      default: begin
        grant_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign grant_valid = |grant;

`ifdef RR_ARBITER_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);

  logic [WDW-1:0] wd_cnt;

  // Counts completed BUSY cycles of the current grant; cleared in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      wd_cnt  <= (state == BUSY) ? wd_cnt + WDW'(1) : '0;
      // Only flag a revoke when the watchdog is the sole reason for release.
      timeout <= expire && !done && req[grant_id];
    end
  end

  assign expire = (state == BUSY) && (wd_cnt == WDW'(TIMEOUT - 1));
`else
  wire unused_timeout_cfg = (TIMEOUT > 0);

  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 SHALL have parameter N, default 8, number of requesters; only 8 is supported.
REQ-002 SHALL have parameter TIMEOUT, default 16, the grant watchdog limit in cycles; it is used only when RR_ARBITER_TIMEOUT_EN is defined.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port req, input, 8 bits: request lines; bit i is asserted by requester i.
REQ-006 SHALL have port done, input, 1 bit: a one-cycle release pulse from the current owner.
REQ-007 SHALL have port grant, output, 8 bits: one-hot registered grant; all zeros when no owner.
REQ-008 SHALL have port grant_id, output, 3 bits: binary index of the current owner.
REQ-009 SHALL have port grant_valid, output, 1 bit: high while grant is non-zero.
REQ-010 SHALL have port timeout, output, 1 bit: a one-cycle pulse when the watchdog revokes a grant; tied 0 when the feature is compiled out.

Function
REQ-011 SHALL implement two states: IDLE (no owner) and BUSY (one owner).
REQ-012 IDLE: if req is non-zero, SHALL select the first asserted bit at index ptr, ptr+1, ... 7, 0, ... ptr-1 (wrap-around).
REQ-013 In the same IDLE case, SHALL register the grant and enter BUSY at the next edge; latency from req to grant is 1 cycle.
REQ-014 IDLE with req == 0 SHALL remain in IDLE with grant = 0.
REQ-015 BUSY SHALL hold grant, grant_id and grant_valid stable; requests from other requesters SHALL NOT pre-empt the owner.
REQ-016 BUSY release SHALL occur when done == 1, or req[grant_id] == 0, or (with the feature enabled) the watchdog expires.
REQ-017 On release, SHALL clear grant, return to IDLE and set ptr = grant_id + 1 mod 8 (7 wraps to 0).
REQ-018 After every release SHALL insert exactly one IDLE cycle before the next grant, even when other requests are pending.
REQ-019 done while in IDLE SHALL be ignored.
REQ-020 done and a simultaneous req drop SHALL be treated as a single release.
REQ-021 grant SHALL always be one-hot or zero; grant_valid SHALL equal |grant.
REQ-022 grant_id SHALL hold its last value while in IDLE.

Reset
REQ-023 reset SHALL immediately force state = IDLE, ptr = 0, grant = 0, grant_id = 0, grant_valid = 0, timeout = 0 and watchdog count = 0.
REQ-024 Reset asserted while in BUSY SHALL drop the grant without waiting for a clock edge.
REQ-025 After reset deassertion, arbitration SHALL restart from index 0 on the first edge.

Configuration
REQ-026 With RR_ARBITER_TIMEOUT_EN defined, the watchdog counter SHALL count BUSY cycles.
REQ-027 When the count reaches TIMEOUT, SHALL force a release and pulse timeout for 1 cycle.
REQ-028 When done and expiry coincide, done SHALL win and timeout SHALL stay 0.
REQ-029 With RR_ARBITER_TIMEOUT_EN undefined, no counter SHALL exist and timeout SHALL be constant 0.

Structure
REQ-030 Shared package arb_pkg SHALL hold: the state encoding (IDLE = 0, BUSY = 1), the constant ARB_N = 8, the constant ARB_IDW = 3 and the default TIMEOUT.
REQ-031 SHALL contain one sub-module, rr_pick: combinational, taking req and ptr and returning a found flag and an index, built as a rotate plus lowest-set-bit priority encode.

Verification
REQ-032 After reset, req = 8'b0000_0000 for 5 cycles -> grant = 0, grant_valid = 0 throughout.
REQ-033 req = 8'b1000_0001 held, done pulsed each BUSY cycle -> grant_id sequence 0, 7, 0, 7, with one IDLE cycle between grants.
REQ-034 req = 8'b1111_1111 held, done after each grant -> grant_id sequence 0, 1, 2, ... 7, 0 (wrap).
REQ-035 Owner 3 granted; req[5] rises; req[3] drops after 4 cycles -> grant stays 8'b0000_1000 for 4 cycles, then IDLE, then grant_id = 5.
REQ-036 With RR_ARBITER_TIMEOUT_EN and TIMEOUT = 4, req[2] held with no done -> timeout pulses once; a BUSY period of exactly 4 cycles, then IDLE, then a re-grant of 2.
REQ-037 reset asserted mid-BUSY with grant_id = 6 -> grant = 0 asynchronously; after release with req = 8'b1100_0000, the next grant_id is 6 (ptr = 0).
